button_debouncer_bank: RTL
==========================

Name: button_debouncer_bank

Overview:
- Parametrised, multi-channel successor to the single-bit push-button edge detector.
- Each channel synchronises a raw button input and filters it with a stability counter, giving a clean level.
- Each channel emits single-cycle press/release pulses and, optionally, auto-repeat pulses while a button is held.
- Sits between board push-buttons and the alarm-clock time-set/mode control logic.

Parameters:
- N_CH, 4, number of independent button channels.
- CNT_W, 20, width of the per-channel stability counter.
- STABLE_CNT, 250000, consecutive differing samples needed to accept a new level; legal range 2 to 2^CNT_W-1.
- HOLD_W, 26, width of the per-channel hold/repeat counter.
- HOLD_CNT, 50000000, cycles from press pulse to first repeat pulse; minimum 2.
- REPEAT_CNT, 10000000, cycles between subsequent repeat pulses; minimum 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_i  in  N_CH  raw, asynchronous button inputs; bit k is channel k.
- level_o  out  N_CH  debounced level per channel.
- press_o  out  N_CH  1-cycle pulse when the debounced level goes 0->1.
- release_o  out  N_CH  1-cycle pulse when the debounced level goes 1->0.
- repeat_o  out  N_CH  1-cycle auto-repeat pulse while held.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low.
- On rst_n low, every register clears immediately regardless of clk:
  - sync FFs, level_o, press_o, release_o, repeat_o all 0;
  - stability and hold counters 0;
  - every FSM in IDLE.
- Channels are fully independent; there is no shared state.
- Synchroniser: 2-FF chain per bit; sync_k is btn_i[k] delayed 2 edges.
- Stability filter:
  - If sync_k != level_k, cnt_k increments.
  - When cnt_k == STABLE_CNT-1 and sync_k still differs, then on that edge level_k <= sync_k and cnt_k <= 0.
  - If sync_k == level_k, cnt_k <= 0, so any bounce restarts the count.
  - Latency from a clean input edge to the level_o change is 2+STABLE_CNT clocks.
- Pulses:
  - press_o[k] / release_o[k] are high for exactly the one cycle following the level_o[k] update.
  - They are registered and aligned with the first cycle of the new level.
- Per-channel FSM:
  - IDLE: level low. On accepted rise, go to HELD; press pulse; hold_cnt <= 0.
  - HELD: hold_cnt increments each cycle. On hold_cnt == HOLD_CNT-1, repeat pulse, hold_cnt <= 0, go to RPT.
  - RPT: hold_cnt increments. On hold_cnt == REPEAT_CNT-1, repeat pulse, hold_cnt <= 0.
  - HELD/RPT: on accepted fall, release pulse; go to IDLE; hold_cnt <= 0.
- Simultaneous release and repeat terminal count: release wins and no repeat pulse is emitted.
- press_o, release_o and repeat_o are never all asserted on one channel in the same cycle; press_o and repeat_o are mutually exclusive.
- A button held through reset deassertion gives a press pulse 2+STABLE_CNT cycles after rst_n rises, because the level resets to 0.
- Counters never wrap: each is cleared at its terminal count, and the widths must hold the parameter values (elaboration-time check).

Optional Feature:
- Macro: DEBOUNCE_AUTO_REPEAT_EN.
- Defined: HELD/RPT repeat logic and hold counters are present as described above.
- Undefined:
  - no hold counters or RPT state;
  - repeat_o is tied to 0;
  - the FSM reduces to IDLE/HELD (press/release only);
  - level, press and release timing is unchanged.

Test Plan (STABLE_CNT=4, HOLD_CNT=10, REPEAT_CNT=3, N_CH=4, macro defined unless stated):
- Reset: hold rst_n low with btn_i=4'hF -> all outputs 0. Release rst_n -> level_o=4'hF and press_o=4'hF pulse on the 6th edge after rst_n rises.
- Bounce: btn_i[0] toggles every 2 cycles for 12 cycles, then holds 1 -> no level_o[0] change during bounce; a single press_o[0] pulse 6 edges after the final toggle.
- Glitch: btn_i[1] high for 3 cycles then low -> level_o[1] stays 0; press_o and release_o stay 0.
- Auto-repeat: btn_i[2] held high; press_o[2] at cycle P -> repeat_o[2] at P+10, P+13, P+16. Release -> release_o[2] once, then no further repeats.
- Collision: time the accepted release on the same cycle as a repeat terminal count -> release_o pulses, repeat_o stays 0.
- Macro undefined: rerun the auto-repeat scenario -> repeat_o == 0 throughout; press_o and release_o timing identical to the defined build.

Source files
------------

// File: rtl/button_debouncer_bank.sv
// Multi-channel push-button debouncer: 2-FF sync, stability filter, press/release pulses.
// Optional auto-repeat while held is enabled by defining DEBOUNCE_AUTO_REPEAT_EN.
module button_debouncer_bank #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 20,
  parameter int STABLE_CNT = 250000,
  parameter int HOLD_W     = 26,
  parameter int HOLD_CNT   = 50000000,
  parameter int REPEAT_CNT = 10000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] repeat_o
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

  // Reject parameter sets whose terminal counts cannot be reached without wrapping.
  if (STABLE_CNT < 2 || longint'(STABLE_CNT) > (longint'(1) << CNT_W) - 1) begin : g_bad_stable
    $error("STABLE_CNT out of range for CNT_W");
  end
  if (HOLD_CNT < 2 || REPEAT_CNT < 2 ||
      longint'(HOLD_CNT) > (longint'(1) << HOLD_W) - 1 ||
      longint'(REPEAT_CNT) > (longint'(1) << HOLD_W) - 1) begin : g_bad_hold
    $error("HOLD_CNT/REPEAT_CNT out of range for HOLD_W");
  end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CNT - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CNT - 1);
`else
  typedef enum logic [1:0] {IDLE, HELD} state_t;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic             meta;
    logic             sync;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_nxt;
    logic             press_q;
    logic             release_q;
    logic             press_nxt;
    logic             release_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta <= 1'b0;
        sync <= 1'b0;
      end else begin
        meta <= btn_i[k];
        sync <= meta;
      end
    end

    // Any sample matching the current level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync == level) begin
        cnt <= '0;
      end else if (cnt == STABLE_LAST) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign rise = (sync != level) && (cnt == STABLE_LAST) && sync;
    assign fall = (sync != level) && (cnt == STABLE_LAST) && !sync;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              repeat_q;
    logic              repeat_nxt;

    // A release on the terminal-count cycle suppresses the repeat pulse.
    always_comb begin
      state_nxt   = state;
      hold_nxt    = hold_cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      repeat_nxt  = 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = HELD;
            hold_nxt  = '0;
            press_nxt = 1'b1;
          end
        end
        HELD, RPT: begin
          if (fall) begin
            state_nxt   = IDLE;
            hold_nxt    = '0;
            release_nxt = 1'b1;
          end else if ((state == HELD && hold_cnt == HOLD_LAST) ||
                       (state == RPT && hold_cnt == REPEAT_LAST)) begin
            state_nxt  = RPT;
            hold_nxt   = '0;
            repeat_nxt = 1'b1;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state     <= state_nxt;
        hold_cnt  <= hold_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        repeat_q  <= repeat_nxt;
      end
    end

    assign repeat_o[k] = repeat_q;
`else
    always_comb begin
      state_nxt   = state;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = HELD;
            press_nxt = 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    assign repeat_o[k] = 1'b0;
`endif

    assign level_o[k]   = level;
    assign press_o[k]   = press_q;
    assign release_o[k] = release_q;
  end

endmodule
